bm_fxp_pack: RTL and testbench



---
 rtl/bm_pkg.sv | 15 +
 rtl/bm_elem_enc.sv | 61 ++++++
 rtl/bm_fxp_pack.sv | 145 ++++++++++++++
 tb/tb_bm_fxp_pack.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bm_pkg.sv
// Shared constants and state encoding for the block-minifloat output packer.
package bm_pkg;
  localparam int unsigned BLK_DEF   = 8;
  localparam int unsigned IN_W_DEF  = 20;
  localparam int unsigned BIAS_W    = 4;
  localparam int unsigned FRAC_W    = 7;
  localparam int unsigned EXP_W     = 2;
  localparam int unsigned MANT_KEEP = 9;
  localparam int          FRAC_MIN  = -64;
  localparam int          FRAC_MAX  = 63;
  localparam int          V_MIN     = -512;
  localparam int          V_MAX     = 511;

  typedef enum logic [1:0] {FILL, CALC, EMIT} state_e;
endpackage

// File: rtl/bm_elem_enc.sv
// Combinational element encoder: block-bias shift with rounding, saturation,
// per-element exponent select and fraction saturation.
module bm_elem_enc
  import bm_pkg::*;
(
  input  logic [IN_W_DEF-1:0] x,
  input  logic [BIAS_W-1:0]   s,
  output logic [FRAC_W-1:0]   dat,
  output logic [EXP_W-1:0]    exp
);
  localparam int unsigned AW = IN_W_DEF + 1;
  localparam int unsigned VW = 11;

  localparam logic signed [AW-1:0] VA_MIN = AW'(V_MIN);
  localparam logic signed [AW-1:0] VA_MAX = AW'(V_MAX);
  localparam logic signed [VW-1:0] VV_MIN = VW'(V_MIN);
  localparam logic signed [VW-1:0] VV_MAX = VW'(V_MAX);
  localparam logic signed [VW-1:0] R0_LO  = VW'(FRAC_MIN);
  localparam logic signed [VW-1:0] R0_HI  = VW'(FRAC_MAX);
  localparam logic signed [VW-1:0] R1_LO  = VW'(2 * FRAC_MIN);
  localparam logic signed [VW-1:0] R1_HI  = VW'(2 * FRAC_MAX + 1);
  localparam logic signed [VW-1:0] R2_LO  = VW'(4 * FRAC_MIN);
  localparam logic signed [VW-1:0] R2_HI  = VW'(4 * FRAC_MAX + 3);
  localparam logic signed [VW-1:0] D_LO   = VW'(FRAC_MIN);
  localparam logic signed [VW-1:0] D_HI   = VW'(FRAC_MAX);

  logic signed [AW-1:0] xe;
  logic signed [AW-1:0] rnd;
  logic signed [AW-1:0] vs;
  logic signed [VW-1:0] v;
  logic signed [VW-1:0] vr;

  always_comb begin
    xe  = {x[IN_W_DEF-1], x};
    rnd = '0;
    v   = '0;
    vr  = '0;
    exp = '0;
    dat = '0;

    // round half toward +inf, then arithmetic shift by the block bias
    if (s != '0) rnd = AW'(1) << (s - 1'b1);
    vs = (xe + rnd) >>> s;

    if (vs > VA_MAX)      v = VV_MAX;
    else if (vs < VA_MIN) v = VV_MIN;
    else                  v = VW'(vs);

    if (v >= R0_LO && v <= R0_HI)      exp = 2'd0;
    else if (v >= R1_LO && v <= R1_HI) exp = 2'd1;
    else if (v >= R2_LO && v <= R2_HI) exp = 2'd2;
    else                               exp = 2'd3;

    if (exp == '0) vr = v;
    else           vr = (v + (VW'(1) << (exp - 1'b1))) >>> exp;

    if (vr > D_HI)      dat = FRAC_W'(FRAC_MAX);
    else if (vr < D_LO) dat = FRAC_W'(FRAC_MIN);
    else                dat = FRAC_W'(vr);
  end
endmodule

// File: rtl/bm_fxp_pack.sv
// Block-minifloat output packer: buffers one block of fixed-point MAC results,
// derives the shared bias from the block maximum, then streams encoded elements.
module bm_fxp_pack
  import bm_pkg::*;
#(
  parameter int unsigned BLK  = BLK_DEF,
  parameter int unsigned IN_W = IN_W_DEF,
  parameter int unsigned CW   = $clog2(BLK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [IN_W-1:0]   in_dat,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [FRAC_W-1:0] out_dat,
  output logic [EXP_W-1:0]  out_exp,
  output logic [BIAS_W-1:0] out_bias,
  output logic              out_first,
  output logic              out_last
);
  localparam int unsigned MAG_W = IN_W - 1;
  localparam int unsigned LW    = $clog2(MAG_W + 1);

  state_e state;
  state_e nxt;

  logic [IN_W-1:0]   mem [BLK];
  logic [CW-1:0]     wr_cnt;
  logic [CW-1:0]     rd_cnt;
  logic [CW-1:0]     ld_idx;
  logic [MAG_W-1:0]  mag_max;
  logic [MAG_W-1:0]  m_in;
  logic [LW-1:0]     lead;
  logic [BIAS_W-1:0] s_calc;
  logic [BIAS_W-1:0] enc_s;
  logic [FRAC_W-1:0] enc_dat;
  logic [EXP_W-1:0]  enc_exp;
  logic              acc;
  logic              hs;
  logic              wr_last;
  logic              rd_last;

  assign acc     = in_vld & in_rdy & (state == FILL);
  assign hs      = out_vld & out_rdy;
  assign wr_last = (wr_cnt == CW'(BLK - 1));
  assign rd_last = (rd_cnt == CW'(BLK - 1));
  assign m_in    = in_dat[IN_W-1] ? ~in_dat[MAG_W-1:0] : in_dat[MAG_W-1:0];

  // bias = bits of the block maximum beyond what the 9-bit pre-exponent range holds
  always_comb begin
    lead   = '0;
    s_calc = '0;
    for (int i = 0; i < int'(MAG_W); i++) begin
      if (mag_max[i]) lead = LW'(i + 1);
    end
    if (lead > LW'(MANT_KEEP)) s_calc = BIAS_W'(lead - LW'(MANT_KEEP));
  end

  assign ld_idx = (state == CALC) ? '0 : CW'(rd_cnt + 1'b1);
  assign enc_s  = (state == CALC) ? s_calc : out_bias;

  bm_elem_enc u_enc (
    .x   (mem[ld_idx]),
    .s   (enc_s),
    .dat (enc_dat),
    .exp (enc_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      FILL:    if (acc && wr_last) nxt = CALC;
      CALC:    nxt = EMIT;
      EMIT:    if (hs && rd_last) nxt = FILL;
      default: nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (acc) mem[wr_cnt] <= in_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_rdy    <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      mag_max   <= '0;
      out_vld   <= 1'b0;
      out_dat   <= '0;
      out_exp   <= '0;
      out_bias  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      in_rdy <= (nxt == FILL);
      case (state)
        FILL: begin
          if (acc) begin
            wr_cnt <= CW'(wr_cnt + 1'b1);
            if (m_in > mag_max) mag_max <= m_in;
          end
        end
        CALC: begin
          out_vld   <= 1'b1;
          out_dat   <= enc_dat;
          out_exp   <= enc_exp;
          out_bias  <= s_calc;
          out_first <= 1'b1;
          out_last  <= (BLK == 1);
          rd_cnt    <= '0;
        end
        EMIT: begin
          if (hs) begin
            if (rd_last) begin
              wr_cnt    <= '0;
              rd_cnt    <= '0;
              mag_max   <= '0;
              out_vld   <= 1'b0;
              out_dat   <= '0;
              out_exp   <= '0;
              out_bias  <= '0;
              out_first <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              rd_cnt    <= ld_idx;
              out_dat   <= enc_dat;
              out_exp   <= enc_exp;
              out_first <= 1'b0;
              out_last  <= (ld_idx == CW'(BLK - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bm_fxp_pack.sv
// Self-checking bench for bm_fxp_pack: directed vector table, randomized blocks
// against an arithmetic reference model, backpressure and reset-discard sequences.
module tb_bm_fxp_pack;
  localparam int BLK = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_vld;
  logic       in_rdy;
  logic [19:0] in_dat;
  logic       out_vld;
  logic       out_rdy;
  logic [6:0] out_dat;
  logic [1:0] out_exp;
  logic [3:0] out_bias;
  logic       out_first;
  logic       out_last;

  int checks = 0;
  int errors = 0;

  typedef int blk_t [BLK];
  typedef struct {
    blk_t x;
    int   bias;
    blk_t d;
    blk_t e;
  } vec_t;

  always #5 clk = ~clk;

  bm_fxp_pack #(.BLK(BLK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_dat    (in_dat),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_dat   (out_dat),
    .out_exp   (out_exp),
    .out_bias  (out_bias),
    .out_first (out_first),
    .out_last  (out_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // reference model from the arithmetic definition of the format
  function automatic int mdl_bias(input blk_t xs);
    int mx = 0;
    int m;
    int l;
    for (int i = 0; i < BLK; i++) begin
      m = (xs[i] >= 0) ? xs[i] : -xs[i] - 1;
      if (m > mx) mx = m;
    end
    l = $clog2(mx + 1);
    return (l > 9) ? l - 9 : 0;
  endfunction

  function automatic void mdl_enc(input int x, input int s, output int d, output int e);
    int v;
    if (s == 0) v = x;
    else        v = (x + (1 << (s - 1))) >>> s;
    if (v > 511)  v = 511;
    if (v < -512) v = -512;
    if (v >= -64 && v <= 63)        e = 0;
    else if (v >= -128 && v <= 127) e = 1;
    else if (v >= -256 && v <= 255) e = 2;
    else                            e = 3;
    if (e == 0) d = v;
    else        d = (v + (1 << (e - 1))) >>> e;
    if (d > 63)  d = 63;
    if (d < -64) d = -64;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_vld = 1'b0;
    out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_rdy", 32'(in_rdy), 0);
    chk("rst_out_vld", 32'(out_vld), 0);
    chk("rst_out_fields", 32'({out_dat, out_exp, out_bias, out_first, out_last}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_rdy", 32'(in_rdy), 1);
  endtask

  task automatic send_elem(input int x);
    bit done = 1'b0;
    int n = 0;
    in_vld = 1'b1;
    in_dat = 20'(x);
    while (!done) begin
      done = in_rdy;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 60) begin
        chk("send_timeout", 0, 1);
        done = 1'b1;
      end
    end
    in_vld = 1'b0;
  endtask

  task automatic check_elem(input int i, input int bias, input int d, input int e);
    chk($sformatf("dat[%0d]", i), 32'(out_dat), d & 32'h7f);
    chk($sformatf("exp[%0d]", i), 32'(out_exp), e);
    chk($sformatf("bias[%0d]", i), 32'(out_bias), bias);
    chk($sformatf("first[%0d]", i), 32'(out_first), (i == 0) ? 1 : 0);
    chk($sformatf("last[%0d]", i), 32'(out_last), (i == BLK - 1) ? 1 : 0);
  endtask

  // mode 0: out_rdy high; 1: 3-cycle stall on element 2; 2: random stalls
  task automatic recv_block(input int bias, input blk_t d, input blk_t e, input int mode);
    int hold;
    for (int i = 0; i < BLK; i++) begin
      int n = 0;
      while (!out_vld && n < 60) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk($sformatf("vld[%0d]", i), 32'(out_vld), 1);
      check_elem(i, bias, d[i], e[i]);
      hold = 0;
      if (mode == 1 && i == 2) hold = 3;
      if (mode == 2) hold = int'($urandom_range(0, 2));
      if (hold > 0) begin
        out_rdy = 1'b0;
        repeat (hold) begin
          @(posedge clk);
          #1;
          check_elem(i, bias, d[i], e[i]);
          chk("stall_in_rdy", 32'(in_rdy), 0);
        end
      end
      out_rdy = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("blk_done_vld", 32'(out_vld), 0);
    chk("blk_done_in_rdy", 32'(in_rdy), 1);
  endtask

  initial begin
    vec_t vt [4];
    blk_t xs;
    blk_t ds;
    blk_t es;
    int   sb;

    vt[0].x = '{5, 5, 5, 5, 5, 5, 5, 5};
    vt[0].bias = 0;
    vt[0].d = '{5, 5, 5, 5, 5, 5, 5, 5};
    vt[0].e = '{0, 0, 0, 0, 0, 0, 0, 0};
    vt[1].x = '{1000, 0, 0, 0, 0, 0, 0, 0};
    vt[1].bias = 1;
    vt[1].d = '{63, 0, 0, 0, 0, 0, 0, 0};
    vt[1].e = '{3, 0, 0, 0, 0, 0, 0, 0};
    vt[2].x = '{524287, -524288, 0, 0, 0, 0, 0, 0};
    vt[2].bias = 10;
    vt[2].d = '{63, -64, 0, 0, 0, 0, 0, 0};
    vt[2].e = '{3, 3, 0, 0, 0, 0, 0, 0};
    vt[3].x = '{600, 3, -3, 0, 0, 0, 0, 0};
    vt[3].bias = 1;
    vt[3].d = '{38, 2, -1, 0, 0, 0, 0, 0};
    vt[3].e = '{3, 0, 0, 0, 0, 0, 0, 0};

    in_dat = '0;
    do_reset();

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < BLK; i++) send_elem(vt[t].x[i]);
      if (t == 0) begin
        chk("lat_calc_vld", 32'(out_vld), 0);
        @(posedge clk);
        #1;
        chk("lat_emit_vld", 32'(out_vld), 1);
      end
      recv_block(vt[t].bias, vt[t].d, vt[t].e, (t == 1) ? 1 : 0);
    end

    for (int b = 0; b < 30; b++) begin
      int sh = int'($urandom_range(0, 19));
      for (int i = 0; i < BLK; i++) begin
        int r = $signed(20'($urandom));
        xs[i] = r >>> (sh + int'($urandom_range(0, 3)));
      end
      sb = mdl_bias(xs);
      for (int i = 0; i < BLK; i++) mdl_enc(xs[i], sb, ds[i], es[i]);
      for (int i = 0; i < BLK; i++) send_elem(xs[i]);
      recv_block(sb, ds, es, 2);
    end

    // reset with a partial block buffered
    send_elem(1000);
    send_elem(-7000);
    send_elem(300);
    do_reset();
    for (int i = 0; i < BLK; i++) begin
      xs[i] = i + 1;
      ds[i] = i + 1;
      es[i] = 0;
    end
    for (int i = 0; i < BLK; i++) send_elem(xs[i]);
    recv_block(0, ds, es, 0);

    // reset with a complete block waiting to be emitted
    out_rdy = 1'b0;
    for (int i = 0; i < BLK; i++) send_elem(200000 - i * 999);
    begin
      int n = 0;
      while (!out_vld && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("held_blk_vld", 32'(out_vld), 1);
    end
    do_reset();
    for (int i = 0; i < BLK; i++) begin
      xs[i] = -(i + 1);
      ds[i] = -(i + 1);
      es[i] = 0;
    end
    for (int i = 0; i < BLK; i++) send_elem(xs[i]);
    recv_block(0, ds, es, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
